mem_wb_writeback: RTL
=====================

# mem_wb_writeback

Parametrised MEM/WB pipeline register plus write-back selection stage for the 5-stage MIPS pipeline. It captures MEM-stage results on each clock and holds them across stalls or squashes them on flushes. From the registered values it drives the register-file write port. It selects among ALU result, size/sign-extracted load data and link address, flags misaligned loads, and counts retired instructions.

## Interface
- DATA_W, 32, datapath width; legal values 32 or 64
- REG_ADDR_W, 5, register-file address width
- COUNT_W, 32, retired-instruction counter width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  hold all stage registers
- flush  input  1  load a bubble (valid=0)
- mem_valid  input  1  MEM-stage slot holds a real instruction
- mem_reg_write  input  1  instruction writes a register
- mem_wb_sel  input  2  write-back source select
- mem_ld_size  input  2  load size
- mem_ld_signed  input  1  sign-extend load data
- mem_rd  input  REG_ADDR_W  destination register
- mem_alu_result  input  DATA_W  ALU result / effective address
- mem_read_data  input  DATA_W  raw aligned memory word
- mem_link  input  DATA_W  return address for link instructions
- wb_we  output  1  register-file write enable
- wb_rd  output  REG_ADDR_W  write address
- wb_data  output  DATA_W  write data
- wb_valid  output  1  registered valid
- wb_misalign  output  1  misaligned load in WB
- wb_retire_count  output  COUNT_W  retired instructions

## Operation
- Register update priority: reset > flush > stall > capture.
  - reset clears every stage register and the counter.
  - flush clears valid and reg_write; other fields are don't-care.
  - stall holds all fields.
  - Otherwise all mem_* fields are captured.
- wb_sel decode: 00 ALU, 01 MEM (extracted), 10 LINK, 11 reserved → ALU.
- ld_size decode:
  - 00 byte, 01 half, 10 word.
  - 11 is double when DATA_W=64; when DATA_W=32 it is treated as word.
- Load extraction:
  - Byte offset = registered alu_result[log2(DATA_W/8)-1:0].
  - The selected byte/half/word lane is shifted to bit 0.
  - The lane is sign-extended when ld_signed=1, zero-extended otherwise.
  - Full-width loads pass through unchanged.
- Misalignment:
  - Condition: a half with odd offset, a word with offset not multiple of 4, or a double with nonzero offset.
  - wb_misalign=1 only when valid, wb_sel=01 and the condition holds; otherwise 0.
- wb_we = valid & reg_write & (rd≠0) & ~wb_misalign.
- wb_rd and wb_data always reflect the registered fields, including when wb_we=0.
- wb_retire_count increments by 1 on each clock edge where wb_valid=1, wb_misalign=0 and stall=0. It wraps modulo 2^COUNT_W.

## Timing
- Latency: 1 cycle from mem_* to wb_*.
- wb_data, wb_we and wb_misalign are combinational from stage registers only; there is no combinational path from mem_* inputs.
- Reset values: wb_we=0, wb_valid=0, wb_misalign=0, wb_rd=0, wb_data=0, wb_retire_count=0.
- flush and stall asserted together: flush wins and a bubble appears in the next cycle.
- Stall held N cycles: outputs constant for N cycles. The counter does not advance during the stall and advances once when the stall releases.
- Reset asserted mid-stream: the next cycle is identical to the post-reset state. In-flight instructions are discarded and not counted.

## Structure
- Shared package mips_pkg holds:
  - WB_SEL_ALU, WB_SEL_MEM and WB_SEL_LINK constants.
  - LD_BYTE, LD_HALF, LD_WORD and LD_DOUBLE constants.
  - Width localparams.
- Sub-module load_extract (params DATA_W)
  - Inputs: raw, offset, size, signed.
  - Outputs: data, misalign.
  - Purely combinational.

## Test plan
- Reset, then an ALU op: alu=0x0000_1234, rd=8, sel=00, reg_write=1 → next cycle wb_we=1, wb_rd=8, wb_data=0x0000_1234, count=1.
- LB signed: read_data=0x80FF_7F01, alu[1:0]=3 → wb_data=0xFFFF_FF80. Same with offset=2 and LBU → 0x0000_00FF.
- LH at offset 1 → wb_misalign=1, wb_we=0, count unchanged. LHU at offset 2 of 0xABCD_0000 → 0x0000_ABCD.
- JAL: sel=10, link=0x0040_0008, rd=31 → wb_data=0x0040_0008. Write to rd=0 with reg_write=1 → wb_we=0 while wb_valid=1.
- Stall 3 cycles with changing mem_* inputs → outputs frozen and count frozen. Assert flush with stall → next cycle wb_valid=0, wb_we=0.
- COUNT_W=4: retire 17 instructions → count=1. Assert reset mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, encodings and width helpers
package mips_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int COUNT_W_DEF    = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_BYTE   = 2'b00,
        LD_HALF   = 2'b01,
        LD_WORD   = 2'b10,
        LD_DOUBLE = 2'b11
    } ld_size_e;

    // Width of the byte offset inside one datapath word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// rtl/mem_wb_writeback_if.sv - MEM-to-WB stage bundle and register-file write port
interface mem_wb_writeback_if #(
    parameter int DATA_W     = mips_pkg::DATA_W_DEF,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W_DEF,
    parameter int COUNT_W    = mips_pkg::COUNT_W_DEF
);

    logic                  stall;
    logic                  flush;
    logic                  mem_valid;
    logic                  mem_reg_write;
    logic [1:0]            mem_wb_sel;
    logic [1:0]            mem_ld_size;
    logic                  mem_ld_signed;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0]     mem_alu_result;
    logic [DATA_W-1:0]     mem_read_data;
    logic [DATA_W-1:0]     mem_link;

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_valid;
    logic                  wb_misalign;
    logic [COUNT_W-1:0]    wb_retire_count;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_wb_sel, mem_ld_size,
               mem_ld_signed, mem_rd, mem_alu_result, mem_read_data, mem_link,
        input  wb_we, wb_rd, wb_data, wb_valid, wb_misalign, wb_retire_count
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_wb_sel, mem_ld_size,
               mem_ld_signed, mem_rd, mem_alu_result, mem_read_data, mem_link,
        output wb_we, wb_rd, wb_data, wb_valid, wb_misalign, wb_retire_count
    );

endinterface

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte/half/word/double lane extraction with sign extension
module load_extract import mips_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    localparam int OFF_W = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              ld_signed,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    localparam logic [DATA_W-1:0] MASK_B = DATA_W'({8{1'b1}});
    localparam logic [DATA_W-1:0] MASK_H = DATA_W'({16{1'b1}});
    localparam logic [DATA_W-1:0] MASK_W = DATA_W'({32{1'b1}});

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;

    assign lane = raw >> {offset, 3'b000};

    always_comb begin
        mask     = MASK_W;
        sign_bit = lane[31];
        misalign = |offset[1:0];
        case (size)
            LD_BYTE: begin
                mask     = MASK_B;
                sign_bit = lane[7];
                misalign = 1'b0;
            end
            LD_HALF: begin
                mask     = MASK_H;
                sign_bit = lane[15];
                misalign = offset[0];
            end
            LD_DOUBLE: begin
                // On a 32-bit datapath a double request degrades to a word load.
                if (DATA_W == 64) begin
                    mask     = '1;
                    sign_bit = 1'b0;
                    misalign = |offset;
                end
            end
            default: begin
            end
        endcase

        if (&mask) begin
            data = raw;
        end else begin
            data = lane & mask;
            if (ld_signed && sign_bit) begin
                data = data | ~mask;
            end
        end
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register with write-back select and retire counter
module mem_wb_writeback import mips_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int COUNT_W    = COUNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mem_wb_writeback_if.slave bus
);

    localparam int OFF_W = off_w(DATA_W);

    logic                  r_valid;
    logic                  r_reg_write;
    logic [1:0]            r_wb_sel;
    logic [1:0]            r_ld_size;
    logic                  r_ld_signed;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_link;
    logic [COUNT_W-1:0]    retire_count;

    logic [DATA_W-1:0]     ex_data;
    logic                  ex_misalign;
    logic                  misalign;
    logic [DATA_W-1:0]     wb_data_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wb_sel    <= '0;
            r_ld_size   <= '0;
            r_ld_signed <= 1'b0;
            r_rd        <= '0;
            r_alu       <= '0;
            r_read_data <= '0;
            r_link      <= '0;
        end else if (bus.flush) begin
            // Only the qualifiers are cleared; payload fields of a bubble are don't-care.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!bus.stall) begin
            r_valid     <= bus.mem_valid;
            r_reg_write <= bus.mem_reg_write;
            r_wb_sel    <= bus.mem_wb_sel;
            r_ld_size   <= bus.mem_ld_size;
            r_ld_signed <= bus.mem_ld_signed;
            r_rd        <= bus.mem_rd;
            r_alu       <= bus.mem_alu_result;
            r_read_data <= bus.mem_read_data;
            r_link      <= bus.mem_link;
        end
    end

    // An instruction retires on the edge it leaves WB, so a stalled edge never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (r_valid && !misalign && !bus.stall) begin
            retire_count <= retire_count + COUNT_W'(1);
        end
    end

    load_extract #(
        .DATA_W(DATA_W)
    ) u_extract (
        .raw      (r_read_data),
        .offset   (r_alu[OFF_W-1:0]),
        .size     (r_ld_size),
        .ld_signed(r_ld_signed),
        .data     (ex_data),
        .misalign (ex_misalign)
    );

    assign misalign = r_valid && (r_wb_sel == WB_SEL_MEM) && ex_misalign;

    always_comb begin
        case (r_wb_sel)
            WB_SEL_MEM:  wb_data_sel = ex_data;
            WB_SEL_LINK: wb_data_sel = r_link;
            default:     wb_data_sel = r_alu;
        endcase
    end

    assign bus.wb_we           = r_valid && r_reg_write && (r_rd != '0) && !misalign;
    assign bus.wb_rd           = r_rd;
    assign bus.wb_data         = wb_data_sel;
    assign bus.wb_valid        = r_valid;
    assign bus.wb_misalign     = misalign;
    assign bus.wb_retire_count = retire_count;

endmodule
